// File: rtl/rca_cfg_encoder_pkg.sv
// Shared definitions for the RCA configuration encoder: instruction
// constants, the fn3 code space, the descriptor record and the phase list.
package rca_cfg_encoder_pkg;

   // Fixed fields of every RCA custom instruction
   localparam logic [6:0] RCA_OPCODE = 7'b0101011;
   localparam logic [6:0] RCA_FN7    = 7'b1000000;

   // Storage width for the grid word counter; the encoder's GRID_CNT_W
   // parameter must not exceed this
   localparam int RCA_GCNT_W = 8;

   // fn3 code space, shared with the decode stage
   typedef enum logic [2:0] {
      FN3_USE_FB     = 3'b000,
      FN3_CPU_REG    = 3'b001,
      FN3_GRID_MUX   = 3'b010,
      FN3_IO_MUX     = 3'b011,
      FN3_RESULT_MUX = 3'b100,
      FN3_IO_USE     = 3'b101,
      FN3_USE_NFB    = 3'b110
   } rca_fn3_t;

   // Emission phases in stream order; the index equals the enable-vector bit
   typedef enum logic [2:0] {
      PH_CPU_REG    = 3'd0,
      PH_GRID_MUX   = 3'd1,
      PH_IO_MUX     = 3'd2,
      PH_RESULT_MUX = 3'd3,
      PH_IO_USE     = 3'd4,
      PH_USE        = 3'd5,
      PH_NONE       = 3'd6
   } rca_phase_t;

   // Descriptor fields latched on acceptance
   typedef struct packed {
      logic [4:0]            accel_id;
      logic [4:0]            phase_mask;
      logic [RCA_GCNT_W-1:0] grid_count;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic                  use_word;
      logic                  use_fb;
   } rca_cfg_desc_t;

   // Lowest enabled phase whose index is at or above start (PH_NONE if none)
   function automatic rca_phase_t first_phase_from(input logic [5:0] en,
                                                   input logic [2:0] start);
      rca_phase_t ph;
      ph = PH_NONE;
      for (int i = 5; i >= 0; i--) begin
         if (en[i] && (i >= int'(start))) begin
            ph = rca_phase_t'(3'(i));
         end
      end
      return ph;
   endfunction

   // fn3 code carried by a word of the given phase
   function automatic rca_fn3_t phase_fn3(input rca_phase_t ph, input logic use_fb);
      rca_fn3_t f;
      case (ph)
         PH_CPU_REG:    f = FN3_CPU_REG;
         PH_GRID_MUX:   f = FN3_GRID_MUX;
         PH_IO_MUX:     f = FN3_IO_MUX;
         PH_RESULT_MUX: f = FN3_RESULT_MUX;
         PH_IO_USE:     f = FN3_IO_USE;
         PH_USE:        f = use_fb ? FN3_USE_FB : FN3_USE_NFB;
         default:       f = FN3_CPU_REG;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/rca_cfg_word_pack.sv
// Packs fn3, source registers and accelerator id into one 32-bit RCA
// instruction word. Purely combinational.
module rca_cfg_word_pack
   import rca_cfg_encoder_pkg::*;
(
   input  logic [2:0]  fn3,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [4:0]  accel_id,
   output logic [31:0] word
);

   // R-type layout with the accelerator id in the rd slot
   always_comb begin
      word = {RCA_FN7, rs2, rs1, fn3, accel_id, RCA_OPCODE};
   end

endmodule

// File: rtl/rca_cfg_encoder.sv
// RCA configuration encoder: accepts one descriptor at a time and emits its
// RCA custom instructions on a valid/ready stream, one word per cycle.
// Build option: define RCA_CFG_ENC_USE_EN to honour cfg_use / cfg_use_fb and
// append the trailing USE word; otherwise those inputs are ignored.
module rca_cfg_encoder
   import rca_cfg_encoder_pkg::*;
#(
   parameter int NUM_ACCELS = 4,
   parameter int GRID_CNT_W = 4
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [4:0]            cfg_accel_id,
   input  logic [4:0]            cfg_phase_mask,
   input  logic [GRID_CNT_W-1:0] cfg_grid_count,
   input  logic [4:0]            cfg_rs1,
   input  logic [4:0]            cfg_rs2,
   input  logic                  cfg_use,
   input  logic                  cfg_use_fb,
   input  logic                  flush,
   output logic [31:0]           instr,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic                  instr_last,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EMIT   = 2'd1,
      ST_FINISH = 2'd2,
      ST_REJECT = 2'd3
   } state_t;

   state_t                state_r;
   rca_cfg_desc_t         desc_r;
   rca_phase_t            phase_r;
   logic [RCA_GCNT_W-1:0] gcnt_r;

   rca_cfg_desc_t         in_desc_s;
   rca_cfg_desc_t         src_desc_s;
   logic [5:0]            en_s;
   rca_phase_t            tgt_phase_s;
   logic [RCA_GCNT_W-1:0] tgt_gcnt_s;
   logic                  tgt_any_s;
   logic                  tgt_last_s;
   logic [4:0]            tgt_rs1_s;
   logic [2:0]            tgt_fn3_s;
   logic [31:0]           word_s;
   logic                  bad_id_s;
   logic                  hs_s;

`ifndef RCA_CFG_ENC_USE_EN
   logic unused_use_s;
   assign unused_use_s = cfg_use ^ cfg_use_fb;
`endif

   // Gather the input ports into a descriptor record (grid count zero-extended)
   always_comb begin
      in_desc_s                             = '0;
      in_desc_s.accel_id                    = cfg_accel_id;
      in_desc_s.phase_mask                  = cfg_phase_mask;
      in_desc_s.grid_count[GRID_CNT_W-1:0]  = cfg_grid_count;
      in_desc_s.rs1                         = cfg_rs1;
      in_desc_s.rs2                         = cfg_rs2;
`ifdef RCA_CFG_ENC_USE_EN
      in_desc_s.use_word                    = cfg_use;
      in_desc_s.use_fb                      = cfg_use_fb;
`else
      in_desc_s.use_word                    = 1'b0;
      in_desc_s.use_fb                      = 1'b0;
`endif
   end

   // Work out the position of the next word to present: the first word of
   // the offered descriptor while idle, else the successor of the current one
   always_comb begin
      src_desc_s  = (state_r == ST_IDLE) ? in_desc_s : desc_r;
      en_s        = {src_desc_s.use_word, src_desc_s.phase_mask};
      tgt_phase_s = PH_NONE;
      tgt_gcnt_s  = '0;
      if (state_r == ST_IDLE) begin
         tgt_phase_s = first_phase_from(en_s, 3'd0);
      end else if ((phase_r == PH_GRID_MUX) && (gcnt_r != src_desc_s.grid_count)) begin
         tgt_phase_s = PH_GRID_MUX;
         tgt_gcnt_s  = gcnt_r + RCA_GCNT_W'(1'b1);
      end else begin
         tgt_phase_s = first_phase_from(en_s, 3'(phase_r) + 3'd1);
      end
      tgt_any_s  = (tgt_phase_s != PH_NONE);
      tgt_last_s = ((tgt_phase_s != PH_GRID_MUX) || (tgt_gcnt_s == src_desc_s.grid_count))
                   && (first_phase_from(en_s, 3'(tgt_phase_s) + 3'd1) == PH_NONE);
      if (tgt_phase_s == PH_GRID_MUX) begin
         tgt_rs1_s = src_desc_s.rs1 + tgt_gcnt_s[4:0];
      end else begin
         tgt_rs1_s = src_desc_s.rs1;
      end
      tgt_fn3_s = phase_fn3(tgt_phase_s, src_desc_s.use_fb);
      bad_id_s  = (32'(cfg_accel_id) >= NUM_ACCELS);
      hs_s      = instr_valid && instr_ready;
   end

   rca_cfg_word_pack u_word_pack (
      .fn3      (tgt_fn3_s),
      .rs1      (tgt_rs1_s),
      .rs2      (src_desc_s.rs2),
      .accel_id (src_desc_s.accel_id),
      .word     (word_s)
   );

   // Sequencer FSM with all outputs registered; flush overrides everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         desc_r      <= '0;
         phase_r     <= PH_NONE;
         gcnt_r      <= '0;
         cfg_ready   <= 1'b1;
         instr       <= 32'd0;
         instr_valid <= 1'b0;
         instr_last  <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else if (flush) begin
         state_r     <= ST_IDLE;
         phase_r     <= PH_NONE;
         gcnt_r      <= '0;
         cfg_ready   <= 1'b1;
         instr       <= 32'd0;
         instr_valid <= 1'b0;
         instr_last  <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (cfg_valid) begin
                  desc_r    <= in_desc_s;
                  phase_r   <= tgt_phase_s;
                  gcnt_r    <= '0;
                  cfg_ready <= 1'b0;
                  if (bad_id_s) begin
                     state_r <= ST_REJECT;
                     err     <= 1'b1;
                  end else if (!tgt_any_s) begin
                     state_r <= ST_FINISH;
                     done    <= 1'b1;
                  end else begin
                     state_r     <= ST_EMIT;
                     instr       <= word_s;
                     instr_valid <= 1'b1;
                     instr_last  <= tgt_last_s;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_EMIT: begin
               if (hs_s) begin
                  if (instr_last) begin
                     state_r     <= ST_FINISH;
                     instr       <= 32'd0;
                     instr_valid <= 1'b0;
                     instr_last  <= 1'b0;
                     done        <= 1'b1;
                  end else begin
                     instr      <= word_s;
                     instr_last <= tgt_last_s;
                     phase_r    <= tgt_phase_s;
                     gcnt_r     <= tgt_gcnt_s;
                  end
               end else begin
                  state_r <= ST_EMIT;
               end
            end
            ST_FINISH: begin
               done      <= 1'b0;
               cfg_ready <= 1'b1;
               state_r   <= ST_IDLE;
            end
            ST_REJECT: begin
               err       <= 1'b0;
               cfg_ready <= 1'b1;
               state_r   <= ST_IDLE;
            end
            default: begin
               state_r     <= ST_IDLE;
               cfg_ready   <= 1'b1;
               instr       <= 32'd0;
               instr_valid <= 1'b0;
               instr_last  <= 1'b0;
               done        <= 1'b0;
               err         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rca_cfg_encoder.sv
// Scoreboard bench for rca_cfg_encoder: directed descriptors from the test
// plan followed by randomized descriptors with random consumer backpressure.
module tb_rca_cfg_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [4:0]  cfg_accel_id;
   logic [4:0]  cfg_phase_mask;
   logic [3:0]  cfg_grid_count;
   logic [4:0]  cfg_rs1;
   logic [4:0]  cfg_rs2;
   logic        cfg_use;
   logic        cfg_use_fb;
   logic        flush;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        instr_last;
   logic        done;
   logic        err;

   int          errors = 0;
   int          checks = 0;
   logic [32:0] exp_q[$];
   int          done_exp = 0;
   int          err_exp = 0;
   int          done_seen = 0;
   int          err_seen = 0;
   int          rdy_mode = 0;
   logic        rdy_fixed = 1'b1;
   logic        held = 1'b0;
   logic [31:0] held_instr;
   logic        held_last;

   always #5 clk = ~clk;

   rca_cfg_encoder #(.NUM_ACCELS(4), .GRID_CNT_W(4)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_accel_id(cfg_accel_id), .cfg_phase_mask(cfg_phase_mask),
      .cfg_grid_count(cfg_grid_count), .cfg_rs1(cfg_rs1), .cfg_rs2(cfg_rs2),
      .cfg_use(cfg_use), .cfg_use_fb(cfg_use_fb), .flush(flush),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_last(instr_last), .done(done), .err(err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] enc(input logic [2:0] f, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [4:0] rd);
      return {7'b1000000, r2, r1, f, rd, 7'b0101011};
   endfunction

   // Reference model: list the words a descriptor must produce
   task automatic push_model(input logic [4:0] id, input logic [4:0] mask, input logic [3:0] gc,
                             input logic [4:0] r1, input logic [4:0] r2,
                             input logic u, input logic ufb);
      logic [31:0] w[$];
      logic        use_on;
      if (id >= 5'd4) begin
         err_exp++;
         return;
      end
`ifdef RCA_CFG_ENC_USE_EN
      use_on = u;
`else
      use_on = u & 1'b0;
`endif
      if (mask[0]) w.push_back(enc(3'b001, r1, r2, id));
      if (mask[1]) begin
         for (int i = 0; i <= int'(gc); i++) w.push_back(enc(3'b010, 5'((int'(r1) + i) % 32), r2, id));
      end
      if (mask[2]) w.push_back(enc(3'b011, r1, r2, id));
      if (mask[3]) w.push_back(enc(3'b100, r1, r2, id));
      if (mask[4]) w.push_back(enc(3'b101, r1, r2, id));
      if (use_on) w.push_back(enc(ufb ? 3'b000 : 3'b110, r1, r2, id));
      for (int k = 0; k < w.size(); k++) exp_q.push_back({(k == w.size() - 1), w[k]});
      done_exp++;
   endtask

   // Offer one descriptor; returns 1 time unit after the accepting edge
   task automatic send(input logic [4:0] id, input logic [4:0] mask, input logic [3:0] gc,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic u, input logic ufb);
      int n = 0;
      @(negedge clk);
      while (!cfg_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!cfg_ready) check("cfg_ready_timeout", {31'd0, cfg_ready}, 32'd1);
      cfg_valid = 1'b1; cfg_accel_id = id; cfg_phase_mask = mask; cfg_grid_count = gc;
      cfg_rs1 = r1; cfg_rs2 = r2; cfg_use = u; cfg_use_fb = ufb;
      push_model(id, mask, gc, r1, r2, u, ufb);
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      cfg_accel_id = 5'($urandom); cfg_phase_mask = 5'($urandom); cfg_grid_count = 4'($urandom);
      cfg_rs1 = 5'($urandom); cfg_rs2 = 5'($urandom); cfg_use = 1'($urandom); cfg_use_fb = 1'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(cfg_ready && exp_q.size() == 0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", {31'd0, cfg_ready}, 32'd1);
   endtask

   // Consumer ready: fixed, random or alternating
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       instr_ready = rdy_fixed;
            1:       instr_ready = 1'($urandom_range(0, 1));
            default: instr_ready = ~instr_ready;
         endcase
      end
   end

   // Monitor: pop and compare on every handshake, check stall stability
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("valid_held", {31'd0, instr_valid}, 32'd1);
               check("instr_stable", instr, held_instr);
               check("last_stable", {31'd0, instr_last}, {31'd0, held_last});
            end
            held = 1'b0;
            if (instr_valid && !flush) begin
               if (!instr_ready) begin
                  held = 1'b1; held_instr = instr; held_last = instr_last;
               end else if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got %h, expected no word", instr);
               end else begin
                  e = exp_q.pop_front();
                  check("word", instr, e[31:0]);
                  check("last", {31'd0, instr_last}, {31'd0, e[32]});
               end
            end
            if (done) done_seen++;
            if (err) err_seen++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; flush = 1'b0;
      cfg_accel_id = 5'd0; cfg_phase_mask = 5'd0; cfg_grid_count = 4'd0;
      cfg_rs1 = 5'd0; cfg_rs2 = 5'd0; cfg_use = 1'b0; cfg_use_fb = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      check("rst_instr", instr, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_last", {31'd0, instr_last}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // single CPU_REG word, exact latency
      send(5'd2, 5'b00001, 4'd0, 5'd10, 5'd11, 1'b0, 1'b0);
      check("t1_word", instr, 32'h80B5112B);
      check("t1_valid", {31'd0, instr_valid}, 32'd1);
      check("t1_last", {31'd0, instr_last}, 32'd1);
      @(posedge clk); #1;
      check("t1_done", {31'd0, done}, 32'd1);
      check("t1_valid_drop", {31'd0, instr_valid}, 32'd0);
      @(posedge clk); #1;
      check("t1_ready_back", {31'd0, cfg_ready}, 32'd1);

      // grid words with rs1 wrap
      send(5'd1, 5'b00010, 4'd2, 5'd30, 5'd7, 1'b0, 1'b0);
      check("t2_first", instr, enc(3'b010, 5'd30, 5'd7, 5'd1));
      wait_idle();

      // full mask with alternating ready
      rdy_mode = 2;
      send(5'd3, 5'b11111, 4'd0, 5'd4, 5'd9, 1'b1, 1'b0);
      wait_idle();
      rdy_mode = 0;

      // empty descriptor
      send(5'd0, 5'b00000, 4'd5, 5'd1, 5'd2, 1'b0, 1'b1);
      check("t4_done", {31'd0, done}, 32'd1);
      check("t4_no_valid", {31'd0, instr_valid}, 32'd0);
      wait_idle();

      // out-of-range accelerator
      send(5'd5, 5'b11111, 4'd3, 5'd1, 5'd1, 1'b1, 1'b1);
      check("t5_err", {31'd0, err}, 32'd1);
      check("t5_no_valid", {31'd0, instr_valid}, 32'd0);
      check("t5_no_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      check("t5_err_pulse", {31'd0, err}, 32'd0);
      wait_idle();

      // flush during the second word of a five-word stream
      rdy_fixed = 1'b1;
      send(5'd1, 5'b00011, 4'd3, 5'd8, 5'd3, 1'b0, 1'b0);
      @(posedge clk);
      rdy_fixed = 1'b0;
      #1;
      @(posedge clk); #1;
      check("t6_stalled", {31'd0, instr_valid}, 32'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("t6_valid_drop", {31'd0, instr_valid}, 32'd0);
      check("t6_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      check("t6_no_done", {31'd0, done}, 32'd0);
      exp_q.delete();
      done_exp--;
      repeat (3) @(posedge clk);
      #1;
      check("t6_still_idle", {31'd0, instr_valid}, 32'd0);

      // asynchronous reset mid-stream
      send(5'd2, 5'b00011, 4'd3, 5'd20, 5'd21, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("t7_valid", {31'd0, instr_valid}, 32'd0);
      check("t7_instr", instr, 32'd0);
      check("t7_last", {31'd0, instr_last}, 32'd0);
      check("t7_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      exp_q.delete();
      done_exp--;
      @(negedge clk);
      rst = 1'b0;
      rdy_fixed = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("t7_quiet", {31'd0, instr_valid}, 32'd0);
      send(5'd3, 5'b01101, 4'd1, 5'd0, 5'd31, 1'b1, 1'b1);
      wait_idle();

      // randomized descriptors with random backpressure
      rdy_mode = 1;
      for (int n = 0; n < 40; n++) begin
         send(5'($urandom_range(0, 5)), 5'($urandom), 4'($urandom), 5'($urandom),
              5'($urandom), 1'($urandom), 1'($urandom));
      end
      wait_idle();
      repeat (5) @(posedge clk);
      #1;
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("done_count", 32'(done_seen), 32'(done_exp));
      check("err_count", 32'(err_seen), 32'(err_exp));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
